// File: rtl/tkm_seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, iterative signed mult and div.
// Define TKM_SEQ_ALU_EARLY_TERM_EN to let mult stop once the remaining multiplier bits are zero.
module tkm_seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);

    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;

`ifdef TKM_SEQ_ALU_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    logic [4:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_div0;
    logic               r_div_ovf;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_sh;
    logic [WIDTH-1:0]   r_q;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_ne;
    logic               r_lt;
    logic               r_ovf;
    logic               r_exc;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_exc;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_iter_op;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic               w_last;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign data_result = r_result;
    assign isNotEqual  = r_ne;
    assign isLessThan  = r_lt;
    assign overflow    = r_ovf;
    assign exception   = r_exc;

    // Single-cycle results, evaluated directly on the operand inputs at accept.
    always_comb begin
        w_sum  = data_operandA + data_operandB;
        w_diff = data_operandA - data_operandB;
        w_res  = '0;
        w_ovf  = 1'b0;
        w_exc  = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_AND: w_res = data_operandA & data_operandB;
            OP_OR:  w_res = data_operandA | data_operandB;
            OP_XOR: w_res = data_operandA ^ data_operandB;
            OP_SLL: w_res = data_operandA << ctrl_shiftamt;
            OP_SRA: w_res = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_MUL, OP_DIV: w_res = '0;
            default: w_exc = 1'b1;
        endcase
    end

    assign w_mag_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign w_iter_op = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);

    // One iteration step; the final step also produces the signed result so DONE follows directly.
    always_comb begin
        w_mul_acc   = r_q[0] ? (r_acc + r_sh) : r_acc;
        w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_sh[WIDTH-1:0]};
        if (r_op == OP_MUL) begin
            w_acc_nxt = w_mul_acc;
            w_sh_nxt  = r_sh << 1;
            w_q_nxt   = r_q >> 1;
        end else begin
            w_acc_nxt = {{WIDTH{1'b0}},
                         w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0]};
            w_sh_nxt  = r_sh;
            w_q_nxt   = {r_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
        end
        w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
        w_quo  = r_neg ? -w_q_nxt : w_q_nxt;
        w_last = (r_cnt == CW'(1)) || (EARLY_TERM && (r_op == OP_MUL) && (w_q_nxt == '0));
    end

    // NOTE: every register below is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_div0      <= 1'b0;
            r_div_ovf   <= 1'b0;
            r_acc       <= '0;
            r_sh        <= '0;
            r_q         <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ne        <= 1'b0;
            r_lt        <= 1'b0;
            r_ovf       <= 1'b0;
            r_exc       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= ctrl_ALUopcode;
                        r_ne <= (data_operandA != data_operandB);
                        r_lt <= ($signed(data_operandA) < $signed(data_operandB));
                        if (w_iter_op) begin
                            r_state   <= S_BUSY;
                            r_cnt     <= CW'(WIDTH);
                            r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                            r_div0    <= (data_operandB == '0);
                            r_div_ovf <= (data_operandA == MIN_VAL) && (data_operandB == '1);
                            r_acc     <= '0;
                            if (ctrl_ALUopcode == OP_MUL) begin
                                r_sh <= {{WIDTH{1'b0}}, w_mag_a};
                                r_q  <= w_mag_b;
                            end else begin
                                r_sh <= {{WIDTH{1'b0}}, w_mag_b};
                                r_q  <= w_mag_a;
                            end
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_ovf       <= w_ovf;
                            r_exc       <= w_exc;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_sh  <= w_sh_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        if (r_op == OP_MUL) begin
                            r_result <= w_prod[WIDTH-1:0];
                            r_ovf    <= (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
                            r_exc    <= 1'b0;
                        end else if (r_div0) begin
                            r_result <= '0;
                            r_ovf    <= 1'b0;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= w_quo;
                            r_ovf    <= r_div_ovf;
                            r_exc    <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tkm_seq_alu.sv
// Directed bench for tkm_seq_alu: scoreboard queue of expected results, immediate-assertion checks.
module tb_tkm_seq_alu;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_BAD = 5'b01111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  ctrl_ALUopcode = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        exception;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        exc;
        logic        ne;
        logic        lt;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    tkm_seq_alu #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .exception      (exception)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Latency of a multiply as seen from accept, depending on the build.
    function automatic int exp_mul_lat(input logic [31:0] b);
`ifdef TKM_SEQ_ALU_EARLY_TERM_EN
        logic [31:0] m;
        int hi;
        m  = b[31] ? -b : b;
        hi = 0;
        for (int i = 0; i < 32; i++) if (m[i]) hi = i;
        return hi + 2;
`else
        return 33;
`endif
    endfunction

    // Called at a negedge; presents one op, pushes the expectation, returns at the negedge after accept.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] res, input logic ovf,
                        input logic exc, input int lat);
        exp_t e;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("send.in_ready", in_ready, 1);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        in_valid       = 1'b1;
        e.res = res;
        e.ovf = ovf;
        e.exc = exc;
        e.ne  = (a != b);
        e.lt  = ($signed(a) < $signed(b));
        e.lat = lat;
        sb.push_back(e);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, compares against the oldest expectation, completes the handshake.
    task automatic collect(input string tag);
        exp_t e;
        int lat;
        check({tag, ".sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            lat = 1;
            while (!out_valid && lat < 200) begin
                @(negedge clock);
                lat++;
            end
            check({tag, ".latency"}, lat, e.lat);
            check({tag, ".result"}, data_result, e.res);
            check({tag, ".overflow"}, overflow, e.ovf);
            check({tag, ".exception"}, exception, e.exc);
            check({tag, ".isNotEqual"}, isNotEqual, e.ne);
            check({tag, ".isLessThan"}, isLessThan, e.lt);
            @(negedge clock);
            check({tag, ".valid_drop"}, out_valid, 0);
        end
    endtask

    initial begin
        exp_t e;

        // Reset state
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.result", data_result, 0);
        check("rst.flags", {isNotEqual, isLessThan, overflow, exception}, 4'b0000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst.in_ready", in_ready, 1);

        // Reset asserted part-way through a multiply aborts it
        ctrl_ALUopcode = OP_MUL;
        data_operandA  = 32'd5;
        data_operandB  = 32'd7;
        in_valid       = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("abort.busy", in_ready, 0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.isNotEqual", isNotEqual, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort.in_ready", in_ready, 1);
        check("abort.no_output", out_valid, 0);
        send(OP_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 1);
        collect("add_after_abort");

        // Single-cycle ops
        send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1);
        collect("add_ovf");
        send(OP_SUB, 32'd5, 32'd9, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1);
        collect("sub_neg");
        send(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        collect("sub_ovf");
        send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1'b0, 1'b0, 1);
        collect("and");
        send(OP_OR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hFFF0_FFFF, 1'b0, 1'b0, 1);
        collect("or");
        send(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hFF00_EDCB, 1'b0, 1'b0, 1);
        collect("xor");
        send(OP_SLL, 32'h0000_0003, 32'h0, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1);
        collect("sll31");
        send(OP_SRA, 32'h8000_1234, 32'h0, 5'd0, 32'h8000_1234, 1'b0, 1'b0, 1);
        collect("sra0");
        send(OP_ADD, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h2468_ACF0, 1'b0, 1'b0, 1);
        collect("add_equal");

        // Multiply
        send(OP_MUL, -32'sd7, 32'd6, 5'd0, 32'hFFFF_FFD6, 1'b0, 1'b0, exp_mul_lat(32'd6));
        collect("mul_neg");
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 1'b1, 1'b0, exp_mul_lat(32'h0001_0000));
        collect("mul_ovf");
        send(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b1, 1'b0, exp_mul_lat(32'hFFFF_FFFF));
        collect("mul_min_m1");
        send(OP_MUL, 32'd100, 32'd3, 5'd0, 32'd300, 1'b0, 1'b0, exp_mul_lat(32'd3));
        collect("mul_100x3");
        send(OP_MUL, 32'd5, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, exp_mul_lat(32'd0));
        collect("mul_by0");
        send(OP_MUL, -32'sd3, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b1, 1'b0, exp_mul_lat(32'h8000_0000));
        collect("mul_by_min");

        // Divide
        send(OP_DIV, -32'sd7, 32'd2, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
        collect("div_neg");
        send(OP_DIV, 32'd9, 32'd0, 5'd0, 32'h0, 1'b0, 1'b1, 33);
        collect("div_by0");
        send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 33);
        collect("div_min_m1");
        send(OP_DIV, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 33);
        collect("div_100_7");
        send(OP_DIV, 32'd7, -32'sd100, 5'd0, 32'd0, 1'b0, 1'b0, 33);
        collect("div_small");

        // Backpressure: result held, in_valid pulses ignored
        out_ready = 1'b0;
        send(OP_SRA, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1);
        check("stall.valid", out_valid, 1);
        check("stall.sb_nonempty", (sb.size() > 0), 1);
        e = sb.pop_front();
        ctrl_ALUopcode = OP_ADD;
        data_operandA  = 32'd1;
        data_operandB  = 32'd1;
        for (int i = 0; i < 10; i++) begin
            check("stall.result", data_result, e.res);
            check("stall.in_ready", in_ready, 0);
            check("stall.out_valid", out_valid, 1);
            in_valid = (i % 2 == 1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("stall.final_result", data_result, e.res);
        check("stall.flags", {isNotEqual, isLessThan, overflow, exception},
              {e.ne, e.lt, e.ovf, e.exc});
        out_ready = 1'b1;
        @(negedge clock);
        check("stall.valid_drop", out_valid, 0);
        @(negedge clock);
        check("stall.no_ghost", out_valid, 0);
        check("stall.in_ready_back", in_ready, 1);

        // Illegal opcode, then a legal op clears the exception
        send(OP_BAD, 32'd12, 32'd34, 5'd3, 32'h0, 1'b0, 1'b1, 1);
        collect("illegal");
        send(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        collect("add_after_illegal");

        check("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
